// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared types and constants for the reset sequencer.
//   rst_state_t    : sequencer FSM states (POR, ASSERT, HOLD, RUN)
//   CAUSE_POR      : cause bit index for power-on / async reset
//   CAUSE_BTN_BASE : cause bit index of button 0 (button i at CAUSE_BTN_BASE+i)
//   cause_sw_idx   : cause bit index of the software request for n_src buttons
//   cause_wdt_idx  : cause bit index of the watchdog for n_src buttons
package rst_seq_pkg;

    typedef enum logic [1:0] {
        POR    = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2,
        RUN    = 2'd3
    } rst_state_t;

    localparam int CAUSE_POR      = 0;
    localparam int CAUSE_BTN_BASE = 1;

    function automatic int cause_sw_idx(input int n_src);
        return n_src + 1;
    endfunction

    function automatic int cause_wdt_idx(input int n_src);
        return n_src + 2;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// One button channel: 2-FF synchroniser followed by a debounce counter.
// The debounced level only flips after DEBOUNCE_CYCLES consecutive
// synchronised samples that differ from it; any agreeing sample restarts
// the count.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-high reset (level returns to released)
//   btn_n  : raw asynchronous button, active-low
//   active : debounced button pressed (debounced level low)
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic active
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_T = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_reg;
    logic            sync2_reg;
    logic            level_reg;
    logic [DB_W-1:0] cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DB_T) begin
                // This is the DEBOUNCE_CYCLES-th differing sample: accept it.
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign active = ~level_reg;

endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen
// Merges N_SRC debounced active-low buttons, a power-on stretch and a
// software reset request into one registered system reset, and records
// a sticky reset-cause register.
// Optional watchdog: define RST_SEQ_WDT_EN to add the wdt_kick port and a
// WDT_CYCLES timeout that forces a reset when RUN goes unkicked.
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-high reset, forces POR
//   btn_n      : raw buttons, active-low
//   sw_rst_req : single-cycle software reset request
//   cause_clr  : clears the cause register (a same-cycle set wins)
//   wdt_kick   : watchdog refresh (RST_SEQ_WDT_EN only)
//   rst_out    : registered system reset, active-high
//   rst_n_out  : registered inverse of rst_out
//   cause      : [0] POR, [i+1] button i, [N_SRC+1] software, [N_SRC+2] watchdog
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int N_SRC           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int POR_CYCLES      = 1024,
    parameter int HOLD_CYCLES     = 16,
    parameter int WDT_CYCLES      = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] btn_n,
    input  logic             sw_rst_req,
    input  logic             cause_clr,
`ifdef RST_SEQ_WDT_EN
    input  logic             wdt_kick,
`endif
    output logic             rst_out,
    output logic             rst_n_out,
    output logic [N_SRC+2:0] cause
);

    localparam int CAUSE_W = N_SRC + 3;
    localparam int SW_IDX  = cause_sw_idx(N_SRC);
    localparam int WDT_IDX = cause_wdt_idx(N_SRC);
    localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_POR;

    localparam int POR_W  = $clog2(POR_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int CNT_W  = (POR_W > HOLD_W) ? POR_W : HOLD_W;
    localparam logic [CNT_W-1:0] POR_T  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES - 1);

    logic [N_SRC-1:0]   active;
    logic               any_act;
    rst_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CAUSE_W-1:0] cause_reg;
    logic [CAUSE_W-1:0] cause_set;
    logic               wdt_fire;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn_debounce (
                .clock  (clock),
                .reset  (reset),
                .btn_n  (btn_n[gi]),
                .active (active[gi])
            );
        end
    endgenerate

    assign any_act = |active;

`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
    localparam logic [WDT_W-1:0] WDT_T = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_reg;

    // A kick in the terminal cycle still counts as a refresh.
    assign wdt_fire = (state_reg == RUN) && !wdt_kick && (wdt_cnt_reg == WDT_T);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdt_cnt_reg <= '0;
        end else if ((state_reg != RUN) || wdt_kick || wdt_fire) begin
            wdt_cnt_reg <= '0;
        end else begin
            wdt_cnt_reg <= wdt_cnt_reg + 1'b1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // Every source that is asserting this cycle either starts or extends a
    // reset (buttons win in all states; software is recorded even when the
    // FSM ignores it), so the cause bits simply follow the sources.
    always_comb begin
        cause_set                        = '0;
        cause_set[CAUSE_BTN_BASE +: N_SRC] = active;
        cause_set[SW_IDX]                = sw_rst_req;
        cause_set[WDT_IDX]               = wdt_fire;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cause_reg <= CAUSE_RST;
        end else begin
            cause_reg <= (cause_clr ? '0 : cause_reg) | cause_set;
        end
    end

    assign cause = cause_reg;

    // rst_out/rst_n_out are updated on the same edge as the state, from the
    // transition being taken, so they are glitch-free registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= POR;
            cnt_reg   <= '0;
            rst_out   <= 1'b1;
            rst_n_out <= 1'b0;
        end else begin
            case (state_reg)
                POR: begin
                    if (any_act) begin
                        state_reg <= ASSERT;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == POR_T) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ASSERT: begin
                    if (!any_act) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end
                end
                HOLD: begin
                    if (any_act) begin
                        state_reg <= ASSERT;
                        cnt_reg   <= '0;
                    end else if (sw_rst_req) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == HOLD_T) begin
                        state_reg <= RUN;
                        rst_out   <= 1'b0;
                        rst_n_out <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (any_act) begin
                        state_reg <= ASSERT;
                        cnt_reg   <= '0;
                        rst_out   <= 1'b1;
                        rst_n_out <= 1'b0;
                    end else if (sw_rst_req || wdt_fire) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                        rst_out   <= 1'b1;
                        rst_n_out <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= POR;
                    cnt_reg   <= '0;
                    rst_out   <= 1'b1;
                    rst_n_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
